ac97_link_tx: RTL and testbench

- AC'97 serial-link frame transmitter. It is the output end of the sound path: it takes PCM samples derived from the channel `level` outputs, plus optional codec register writes.
- It serialises them into 256-bit AC'97 frames on `ac97_sdata_out` and `ac97_sync`, clocked by `ac97_bitclk`.
- It issues one sample-request strobe per frame (48 kHz), which paces the sample producers.

---
 rtl/ac97_link_tx.sv | 101 ++++++++++
 tb/tb_ac97_link_tx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ac97_link_tx.sv
// ac97_link_tx: AC'97 frame serialiser (tag + slots 1-4) with one sample_req per 256-bit frame.
// Build option AC97_MIXER_EN: slots 3/4 carry summed channel levels instead of left/right_sample.
module ac97_link_tx #(
    parameter int SLOT_WIDTH = 20,
    parameter int TAG_WIDTH  = 16
) (
    input  logic                  ac97_bitclk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [SLOT_WIDTH-1:0] left_sample,
    input  logic [SLOT_WIDTH-1:0] right_sample,
`ifdef AC97_MIXER_EN
    input  logic [3:0]            ch1_level,
    input  logic [3:0]            ch2_level,
    input  logic [3:0]            ch3_level,
    input  logic [3:0]            ch4_level,
    input  logic [3:0]            ch_left_en,
    input  logic [3:0]            ch_right_en,
`endif
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [6:0]            cmd_addr,
    input  logic [15:0]           cmd_data,
    output logic                  sample_req,
    output logic                  ac97_sync,
    output logic                  ac97_sdata_out
);
    localparam int FRAME_W = TAG_WIDTH + 12 * SLOT_WIDTH;

    logic [7:0]            r_bit_cnt;
    logic                  r_full;
    logic [6:0]            r_addr;
    logic [15:0]           r_data;
    logic [FRAME_W-1:0]    r_shift;
    logic                  r_sdata;
    logic                  r_sync;
    logic                  r_sample_req;
    logic                  w_load;
    logic                  w_send_cmd;
    logic [TAG_WIDTH-1:0]  w_tag;
    logic [SLOT_WIDTH-1:0] w_slot1;
    logic [SLOT_WIDTH-1:0] w_slot2;
    logic [SLOT_WIDTH-1:0] w_left;
    logic [SLOT_WIDTH-1:0] w_right;
    logic [FRAME_W-1:0]    w_frame;
    logic [FRAME_W-1:0]    w_src;

`ifdef AC97_MIXER_EN
    logic [5:0] w_sum_l;
    logic [5:0] w_sum_r;
    assign w_sum_l = ({2'b00, ch1_level} & {6{ch_left_en[0]}}) + ({2'b00, ch2_level} & {6{ch_left_en[1]}})
                   + ({2'b00, ch3_level} & {6{ch_left_en[2]}}) + ({2'b00, ch4_level} & {6{ch_left_en[3]}});
    assign w_sum_r = ({2'b00, ch1_level} & {6{ch_right_en[0]}}) + ({2'b00, ch2_level} & {6{ch_right_en[1]}})
                   + ({2'b00, ch3_level} & {6{ch_right_en[2]}}) + ({2'b00, ch4_level} & {6{ch_right_en[3]}});
    assign w_left  = {2'b00, w_sum_l, {(SLOT_WIDTH-8){1'b0}}};
    assign w_right = {2'b00, w_sum_r, {(SLOT_WIDTH-8){1'b0}}};
`else
    assign w_left  = left_sample;
    assign w_right = right_sample;
`endif

    assign w_load     = r_bit_cnt == 8'hFF;
    assign w_send_cmd = enable && r_full;
    assign w_tag      = {enable, w_send_cmd, w_send_cmd, enable, enable, {(TAG_WIDTH-5){1'b0}}};
    assign w_slot1    = w_send_cmd ? {1'b0, r_addr, {(SLOT_WIDTH-8){1'b0}}} : '0;
    assign w_slot2    = w_send_cmd ? {r_data, {(SLOT_WIDTH-16){1'b0}}} : '0;
    // Frame is MSB-first: bit FRAME_W-1 is frame bit 0 (valid-frame tag bit)
    assign w_frame    = enable ? {w_tag, w_slot1, w_slot2, w_left, w_right, {(8*SLOT_WIDTH){1'b0}}} : '0;
    assign w_src      = w_load ? w_frame : r_shift;

    assign cmd_ready      = ~r_full;
    assign sample_req     = r_sample_req;
    assign ac97_sync      = r_sync;
    assign ac97_sdata_out = r_sdata;

    always_ff @(posedge ac97_bitclk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt    <= 8'hFF;
            r_full       <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_shift      <= '0;
            r_sdata      <= 1'b0;
            r_sync       <= 1'b0;
            r_sample_req <= 1'b0;
        end else begin
            r_bit_cnt    <= r_bit_cnt + 8'd1;
            r_sample_req <= r_bit_cnt == 8'd254;
            r_sync       <= w_load || (r_bit_cnt < 8'd15);
            r_sdata      <= w_src[FRAME_W-1];
            r_shift      <= {w_src[FRAME_W-2:0], 1'b0};
            if (w_load && w_send_cmd) begin
                r_full <= 1'b0;
            end else if (cmd_valid && !r_full) begin
                r_full <= 1'b1;
                r_addr <= cmd_addr;
                r_data <= cmd_data;
            end
        end
    end
endmodule

// File: tb/tb_ac97_link_tx.sv
// tb_ac97_link_tx: scoreboard bench; driver queues expected frames per load, monitor deserialises and compares.
module tb_ac97_link_tx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic [19:0] left_sample = '0;
    logic [19:0] right_sample = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [6:0]  cmd_addr = '0;
    logic [15:0] cmd_data = '0;
    logic        sample_req;
    logic        ac97_sync;
    logic        ac97_sdata_out;
`ifdef AC97_MIXER_EN
    logic [3:0]  ch1_level = 4'd15;
    logic [3:0]  ch2_level = 4'd15;
    logic [3:0]  ch3_level = 4'd15;
    logic [3:0]  ch4_level = 4'd15;
    logic [3:0]  ch_left_en = 4'hF;
    logic [3:0]  ch_right_en = 4'h1;
`endif

    int checks = 0;
    int errors = 0;
    logic [255:0] exp_q[$];

    always #5 clk = ~clk;

    ac97_link_tx dut (
        .ac97_bitclk   (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .left_sample   (left_sample),
        .right_sample  (right_sample),
`ifdef AC97_MIXER_EN
        .ch1_level     (ch1_level),
        .ch2_level     (ch2_level),
        .ch3_level     (ch3_level),
        .ch4_level     (ch4_level),
        .ch_left_en    (ch_left_en),
        .ch_right_en   (ch_right_en),
`endif
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_data      (cmd_data),
        .sample_req    (sample_req),
        .ac97_sync     (ac97_sync),
        .ac97_sdata_out(ac97_sdata_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_req && n < 600);
        chk({name, "_req"}, {31'b0, sample_req}, 1);
    endtask

    task automatic push_exp(input logic [15:0] tag, input logic [19:0] s1, input logic [19:0] s2,
                            input logic [19:0] l, input logic [19:0] r);
`ifdef AC97_MIXER_EN
        if (tag != 16'h0) begin
            l = 20'h3C000;
            r = 20'h0F000;
        end
`endif
        exp_q.push_back({tag, s1, s2, l, r, 160'b0});
    endtask

    logic [255:0] cap;
    int idx = -1;
    int sync_bad = 0;
    logic prev_sync = 1'b0;

    task automatic check_frame();
        logic [255:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_unexpected: got frame %h required none", cap);
            return;
        end
        e = exp_q.pop_front();
        chk("tag", {16'b0, cap[255:240]}, {16'b0, e[255:240]});
        chk("slot1", {12'b0, cap[239:220]}, {12'b0, e[239:220]});
        chk("slot2", {12'b0, cap[219:200]}, {12'b0, e[219:200]});
        chk("slot3", {12'b0, cap[199:180]}, {12'b0, e[199:180]});
        chk("slot4", {12'b0, cap[179:160]}, {12'b0, e[179:160]});
        chk("slots5_12_ones", $countones(cap[159:0]), 0);
        chk("sync_shape_bad_bits", sync_bad, 0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            idx = -1;
        end else begin
            if (ac97_sync && !prev_sync) begin
                idx = 0;
                sync_bad = 0;
            end
            if (idx >= 0) begin
                cap[255-idx] = ac97_sdata_out;
                if (ac97_sync !== ((idx <= 15) ? 1'b1 : 1'b0)) sync_bad++;
                idx++;
                if (idx == 256) begin
                    idx = -1;
                    check_frame();
                end
            end
        end
        prev_sync = ac97_sync;
    end

    int cyc_n = 0;
    int last_req = -1;
    always @(negedge clk) begin
        cyc_n++;
        if (!rst_n) begin
            last_req = -1;
        end else if (sample_req) begin
            if (last_req >= 0) chk("req_period", cyc_n - last_req, 256);
            last_req = cyc_n;
        end
    end

    initial begin
        cyc(3);
        chk("rst_sync", {31'b0, ac97_sync}, 0);
        chk("rst_sdata", {31'b0, ac97_sdata_out}, 0);
        chk("rst_req", {31'b0, sample_req}, 0);
        chk("rst_ready", {31'b0, cmd_ready}, 1);
        left_sample = 20'h12345;
        right_sample = 20'hABCDE;
        push_exp(16'h9800, 20'h0, 20'h0, 20'h12345, 20'hABCDE);
        rst_n = 1'b1;
        cyc(20);
        cmd_addr = 7'h02;
        cmd_data = 16'h8000;
        cmd_valid = 1'b1;
        cyc(1);
        cmd_valid = 1'b0;
        chk("ready_after_accept_a", {31'b0, cmd_ready}, 0);
        wait_req("l1");
        left_sample = 20'h54321;
        right_sample = 20'h0F0F0;
        push_exp(16'hF800, 20'h02000, 20'h80000, 20'h54321, 20'h0F0F0);
        cyc(1);
        chk("ready_after_load_a", {31'b0, cmd_ready}, 1);
        wait_req("l2");
        left_sample = 20'h00001;
        right_sample = 20'hFFFFF;
        push_exp(16'h9800, 20'h0, 20'h0, 20'h00001, 20'hFFFFF);
        cyc(10);
        left_sample = 20'hFEDCB;
        right_sample = 20'h0;
        cmd_addr = 7'h7F;
        cmd_data = 16'h1234;
        cmd_valid = 1'b1;
        cyc(1);
        chk("ready_after_accept_b", {31'b0, cmd_ready}, 0);
        cmd_addr = 7'h55;
        cmd_data = 16'hBEEF;
        wait_req("l3");
        chk("ready_full_before_l3", {31'b0, cmd_ready}, 0);
        left_sample = 20'hAAAAA;
        right_sample = 20'h55555;
        push_exp(16'hF800, 20'h7F000, 20'h12340, 20'hAAAAA, 20'h55555);
        cyc(1);
        chk("ready_after_load_b", {31'b0, cmd_ready}, 1);
        cyc(1);
        cmd_valid = 1'b0;
        chk("ready_after_accept_c", {31'b0, cmd_ready}, 0);
        wait_req("l4");
        enable = 1'b0;
        left_sample = 20'h11111;
        right_sample = 20'h22222;
        push_exp(16'h0, 20'h0, 20'h0, 20'h0, 20'h0);
        cyc(1);
        enable = 1'b1;
        chk("ready_held_disabled", {31'b0, cmd_ready}, 0);
        wait_req("l5");
        left_sample = 20'h33333;
        right_sample = 20'h44444;
        push_exp(16'hF800, 20'h55000, 20'hBEEF0, 20'h33333, 20'h44444);
        cyc(1);
        chk("ready_after_load_c", {31'b0, cmd_ready}, 1);
        wait_req("l6");
        left_sample = 20'h80000;
        right_sample = 20'h7FFFF;
        push_exp(16'h9800, 20'h0, 20'h0, 20'h80000, 20'h7FFFF);
        cyc(10);
        cmd_addr = 7'h11;
        cmd_data = 16'h2222;
        cmd_valid = 1'b1;
        cyc(1);
        cmd_valid = 1'b0;
        chk("ready_after_accept_d", {31'b0, cmd_ready}, 0);
        cyc(90);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_sync", {31'b0, ac97_sync}, 0);
        chk("midrst_sdata", {31'b0, ac97_sdata_out}, 0);
        chk("midrst_req", {31'b0, sample_req}, 0);
        chk("midrst_ready", {31'b0, cmd_ready}, 1);
        cyc(3);
        left_sample = 20'h0F0F0;
        right_sample = 20'h00001;
        push_exp(16'h9800, 20'h0, 20'h0, 20'h0F0F0, 20'h00001);
        rst_n = 1'b1;
        wait_req("l8");
        left_sample = 20'hFFFFF;
        right_sample = 20'h00000;
        push_exp(16'h9800, 20'h0, 20'h0, 20'hFFFFF, 20'h00000);
        for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
